// File: rtl/i2c_eeprom_slave.sv
// 24Cxx-style I2C EEPROM target; define I2C_SLAVE_ADDR16_EN for two word-address bytes (default: one).
// Pad edges seen 3 clk late; SDA drive changes 1 clk after a detected SCL fall; no backpressure (I2C timing only).
module i2c_eeprom_slave #(
  parameter logic [6:0] DEV_ADDR = 7'h50,
  parameter int         AW       = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          scl_i,
  input  logic          sda_i,
  output logic          sda_oe,
  output logic          wr_stb,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          busy
);

  typedef enum logic [3:0] {
    IDLE,
    DEV,
    DEV_ACK,
`ifdef I2C_SLAVE_ADDR16_EN
    ADDR_H,
    ADDR_H_ACK,
`endif
    ADDR_L,
    ADDR_L_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK
  } state_t;

  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic          scl_s1, scl_s2, scl_d;
  logic          sda_s1, sda_s2, sda_d;
  state_t        state;
  logic [2:0]    cnt;
  logic [7:0]    sh;
  logic [AW-1:0] ptr;
  logic [AW-1:0] waddr;
  logic          rw;
  logic          ack_ph;
  logic [7:0]    mem [0:(1<<AW)-1];

  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] rx_byte;

  // START/STOP need SCL high in both sampled cycles, so an SCL edge coincident
  // with an SDA change is treated as a data bit.
  always_comb begin
    scl_rise  = scl_s2 & ~scl_d;
    scl_fall  = ~scl_s2 & scl_d;
    start_det = scl_s2 & scl_d & sda_d & ~sda_s2;
    stop_det  = scl_s2 & scl_d & ~sda_d & sda_s2;
    rx_byte   = {sh[6:0], sda_s2};
  end

  // Contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_stb) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_s1  <= 1'b1;
      scl_s2  <= 1'b1;
      scl_d   <= 1'b1;
      sda_s1  <= 1'b1;
      sda_s2  <= 1'b1;
      sda_d   <= 1'b1;
      state   <= IDLE;
      cnt     <= 3'd0;
      sh      <= 8'h00;
      ptr     <= '0;
      waddr   <= '0;
      rw      <= 1'b0;
      ack_ph  <= 1'b0;
      sda_oe  <= 1'b0;
      wr_stb  <= 1'b0;
      wr_addr <= '0;
      wr_data <= 8'h00;
      busy    <= 1'b0;
    end else begin
      scl_s1 <= scl_i;
      scl_s2 <= scl_s1;
      scl_d  <= scl_s2;
      sda_s1 <= sda_i;
      sda_s2 <= sda_s1;
      sda_d  <= sda_s2;
      wr_stb <= 1'b0;

      if (start_det) begin
        state  <= DEV;
        cnt    <= 3'd0;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else if (stop_det) begin
        state  <= IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else begin
        // Received bits and outgoing read data share one shift register.
        if (scl_rise) sh <= rx_byte;

        case (state)
          DEV: if (scl_rise) begin
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              if (rx_byte[7:1] == DEV_ADDR) begin
                rw     <= rx_byte[0];
                ack_ph <= 1'b0;
                state  <= DEV_ACK;
              end else begin
                state <= IDLE;
              end
            end
          end

          DEV_ACK: if (scl_fall) begin
            if (!ack_ph) begin
              sda_oe <= 1'b1;
              busy   <= 1'b1;
              ack_ph <= 1'b1;
            end else if (rw) begin
              sh     <= mem[ptr];
              sda_oe <= ~mem[ptr][7];
              cnt    <= 3'd0;
              state  <= RDATA;
            end else begin
              sda_oe <= 1'b0;
              cnt    <= 3'd0;
`ifdef I2C_SLAVE_ADDR16_EN
              state  <= ADDR_H;
`else
              state  <= ADDR_L;
`endif
            end
          end

`ifdef I2C_SLAVE_ADDR16_EN
          ADDR_H: if (scl_rise) begin
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              waddr  <= AW'(rx_byte);
              ack_ph <= 1'b0;
              state  <= ADDR_H_ACK;
            end
          end

          ADDR_H_ACK: if (scl_fall) begin
            if (!ack_ph) begin
              sda_oe <= 1'b1;
              ack_ph <= 1'b1;
            end else begin
              sda_oe <= 1'b0;
              cnt    <= 3'd0;
              state  <= ADDR_L;
            end
          end
`endif

          ADDR_L: if (scl_rise) begin
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7) begin
`ifdef I2C_SLAVE_ADDR16_EN
              waddr <= AW'({waddr, rx_byte});
`else
              waddr <= AW'(rx_byte);
`endif
              ack_ph <= 1'b0;
              state  <= ADDR_L_ACK;
            end
          end

          ADDR_L_ACK: if (scl_fall) begin
            if (!ack_ph) begin
              sda_oe <= 1'b1;
              ack_ph <= 1'b1;
            end else begin
              sda_oe <= 1'b0;
              ptr    <= waddr;
              cnt    <= 3'd0;
              state  <= WDATA;
            end
          end

          WDATA: if (scl_rise) begin
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              wr_stb  <= 1'b1;
              wr_addr <= ptr;
              wr_data <= rx_byte;
              ptr     <= ptr + PTR_ONE;
              ack_ph  <= 1'b0;
              state   <= WDATA_ACK;
            end
          end

          WDATA_ACK: if (scl_fall) begin
            if (!ack_ph) begin
              sda_oe <= 1'b1;
              ack_ph <= 1'b1;
            end else begin
              sda_oe <= 1'b0;
              cnt    <= 3'd0;
              state  <= WDATA;
            end
          end

          RDATA: begin
            if (scl_rise) begin
              cnt <= cnt + 3'd1;
              if (cnt == 3'd7) begin
                ack_ph <= 1'b0;
                state  <= RDATA_ACK;
              end
            end else if (scl_fall) begin
              sda_oe <= ~sh[7];
            end
          end

          // Release for the master's ACK slot; a NACK leaves busy set until STOP/START.
          RDATA_ACK: begin
            if (scl_fall && !ack_ph) begin
              sda_oe <= 1'b0;
              ack_ph <= 1'b1;
            end else if (scl_rise && ack_ph) begin
              if (sda_s2) state <= IDLE;
              else        ptr   <= ptr + PTR_ONE;
            end else if (scl_fall && ack_ph) begin
              sh     <= mem[ptr];
              sda_oe <= ~mem[ptr][7];
              cnt    <= 3'd0;
              state  <= RDATA;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// Directed bench for i2c_eeprom_slave: bit-banged I2C master over an open-drain SDA model.
module tb_i2c_eeprom_slave;

  localparam int Q = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_oe, wr_stb, busy;
  logic [7:0] wr_addr, wr_data;
  wire        sda_line = sda_m & ~sda_oe;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int oe_cnt = 0;
  logic [7:0] wa_q [$];
  logic [7:0] wd_q [$];

  always #5 clk = ~clk;

  i2c_eeprom_slave dut (
    .clk     (clk),
    .rst     (rst),
    .scl_i   (scl),
    .sda_i   (sda_line),
    .sda_oe  (sda_oe),
    .wr_stb  (wr_stb),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .busy    (busy)
  );

  always @(negedge clk) begin
    if (wr_stb) begin
      wr_cnt++;
      wa_q.push_back(wr_addr);
      wd_q.push_back(wr_data);
    end
    if (sda_oe) oe_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_cycle(input logic b, output logic line, output logic oe);
    sda_m = b;
    tick(Q);
    scl = 1'b1;
    tick(Q);
    line = sda_line;
    oe = sda_oe;
    tick(Q);
    scl = 1'b0;
    tick(Q);
  endtask

  task automatic i2c_start;
    sda_m = 1'b1;
    tick(Q);
    scl = 1'b1;
    tick(Q);
    sda_m = 1'b0;
    tick(Q);
    scl = 1'b0;
    tick(Q);
  endtask

  task automatic i2c_stop;
    sda_m = 1'b0;
    tick(Q);
    scl = 1'b1;
    tick(Q);
    sda_m = 1'b1;
    tick(Q);
  endtask

  task automatic send_byte(input logic [7:0] d, output logic acked);
    logic l, o;
    for (int i = 7; i >= 0; i--) bit_cycle(d[i], l, o);
    bit_cycle(1'b1, l, o);
    acked = ~l;
  endtask

  task automatic send_word_addr(input logic [7:0] a, output logic acked);
    logic a1;
    acked = 1'b1;
`ifdef I2C_SLAVE_ADDR16_EN
    send_byte(8'h00, a1);
    acked = acked & a1;
`endif
    send_byte(a, a1);
    acked = acked & a1;
  endtask

  task automatic recv_byte(input logic m_ack, output logic [7:0] d, output logic oe_ack);
    logic l, o;
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(1'b1, l, o);
      d[i] = l;
    end
    bit_cycle(~m_ack, l, o);
    oe_ack = o;
  endtask

  initial begin
    logic       ack, oe, l;
    logic [7:0] d;
    logic [7:0] seq_d [4];
    int         n0, o0;
    seq_d[0] = 8'h11; seq_d[1] = 8'h22; seq_d[2] = 8'h33; seq_d[3] = 8'h44;

    tick(3);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_wr_stb", wr_stb, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    tick(Q);

    // single-byte write 0xA5 -> 0x12
    i2c_start;
    send_byte(8'hA0, ack);
    check("w1_dev_ack", ack, 1);
    check("w1_busy", busy, 1);
    send_word_addr(8'h12, ack);
    check("w1_addr_ack", ack, 1);
    send_byte(8'hA5, ack);
    check("w1_data_ack", ack, 1);
    check("w1_wr_cnt", wr_cnt, 1);
    check("w1_wr_addr", wa_q[0], 8'h12);
    check("w1_wr_data", wd_q[0], 8'hA5);
    i2c_stop;
    check("w1_busy_stop", busy, 0);

    // random read at 0x12
    i2c_start;
    send_byte(8'hA0, ack);
    send_word_addr(8'h12, ack);
    i2c_start;
    send_byte(8'hA1, ack);
    check("r1_dev_ack", ack, 1);
    recv_byte(1'b0, d, oe);
    check("r1_data", d, 8'hA5);
    check("r1_oe_in_ack", oe, 0);
    check("r1_busy_after_nack", busy, 1);
    i2c_stop;
    check("r1_busy_stop", busy, 0);

    // sequential write wrapping 0xFF -> 0x00
    i2c_start;
    send_byte(8'hA0, ack);
    send_word_addr(8'hFE, ack);
    check("sw_addr_ack", ack, 1);
    for (int i = 0; i < 4; i++) begin
      send_byte(seq_d[i], ack);
      check("sw_data_ack", ack, 1);
    end
    i2c_stop;
    check("sw_wr_cnt", wr_cnt, 5);
    check("sw_addr0", wa_q[1], 8'hFE);
    check("sw_addr1", wa_q[2], 8'hFF);
    check("sw_addr2", wa_q[3], 8'h00);
    check("sw_addr3", wa_q[4], 8'h01);
    check("sw_data3", wd_q[4], 8'h44);

    // sequential read from 0xFE: ACK, ACK, ACK, NACK
    i2c_start;
    send_byte(8'hA0, ack);
    send_word_addr(8'hFE, ack);
    i2c_start;
    send_byte(8'hA1, ack);
    check("sr_dev_ack", ack, 1);
    for (int i = 0; i < 4; i++) begin
      recv_byte(i != 3, d, oe);
      check("sr_data", d, seq_d[i]);
      check("sr_oe_in_ack", oe, 0);
    end
    i2c_stop;

    // wrong device address
    n0 = wr_cnt;
    o0 = oe_cnt;
    i2c_start;
    send_byte(8'hA2, ack);
    check("na_dev_ack", ack, 0);
    send_byte(8'h00, ack);
    check("na_data_ack", ack, 0);
    i2c_stop;
    check("na_oe_cycles", oe_cnt, o0);
    check("na_wr_cnt", wr_cnt, n0);
    check("na_busy", busy, 0);

    // STOP after 5 data bits, then a clean write
    i2c_start;
    send_byte(8'hA0, ack);
    send_word_addr(8'h30, ack);
    for (int i = 0; i < 5; i++) bit_cycle(i[0], l, oe);
    i2c_stop;
    check("ps_wr_cnt", wr_cnt, n0);
    check("ps_busy", busy, 0);
    i2c_start;
    send_byte(8'hA0, ack);
    check("ps_dev_ack", ack, 1);
    send_word_addr(8'h30, ack);
    send_byte(8'h5A, ack);
    check("ps_data_ack", ack, 1);
    check("ps_wr_cnt2", wr_cnt, n0 + 1);
    check("ps_wr_addr", wa_q[wa_q.size()-1], 8'h30);
    check("ps_wr_data", wd_q[wd_q.size()-1], 8'h5A);
    i2c_stop;

    // reset while driving the device-address ACK
    i2c_start;
    for (int i = 7; i >= 0; i--) bit_cycle(((8'hA0 >> i) & 8'h01) != 0, l, oe);
    check("ra_oe_before", sda_oe, 1);
    check("ra_busy_before", busy, 1);
    rst = 1'b1;
    #1;
    check("ra_oe_async", sda_oe, 0);
    check("ra_busy_async", busy, 0);
    tick(3);
    rst = 1'b0;
    tick(Q);
    // pointer back at 0 -> current-address read returns mem[0]
    i2c_start;
    send_byte(8'hA1, ack);
    check("ra_dev_ack", ack, 1);
    recv_byte(1'b0, d, oe);
    check("ra_ptr0_data", d, 8'h33);
    i2c_stop;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_eeprom_slave.md
# i2c_eeprom_slave

I2C target (responder) that emulates a 24Cxx-style serial EEPROM: it decodes START/STOP, matches a 7-bit device address, accepts a word address, and performs sequential byte writes into or reads from an internal byte array. It is the far end of our I2C master/EEPROM controller path. It is used as an on-chip loopback target and as a bench model for the master. The SDA pad stays in the top level; this block sees only sampled SCL/SDA and an open-drain pull-low enable.

## Interface
- DEV_ADDR, 7'h50, 7-bit device address the block answers to.
- AW, 8, internal pointer/memory address width; memory depth is 2**AW bytes.
- clk  input  1  system clock; must be at least 20× the SCL frequency.
- rst  input  1  reset, asynchronous, active-high.
- scl_i  input  1  raw SCL from pad; asynchronous.
- sda_i  input  1  raw SDA from pad; asynchronous.
- sda_oe  output  1  1 = pull SDA low; 0 = release (pad is tri-stated, pulled high externally).
- wr_stb  output  1  one-clk pulse per byte written to memory.
- wr_addr  output  AW  address of the byte written (valid with wr_stb).
- wr_data  output  8  data written (valid with wr_stb).
- busy  output  1  1 from a matched device address until the next STOP/START.

## Operation
- Inputs pass through 2-flop synchronizers, then a third register for edge detection.
- Edges:
  - SCL rise/fall are taken from the synchronized signal.
  - START = SDA falls while SCL is high; STOP = SDA rises while SCL is high.
- States: IDLE, DEV, DEV_ACK, ADDR_H, ADDR_H_ACK, ADDR_L, ADDR_L_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
- Data bits are sampled on SCL rise, MSB first. A 3-bit counter counts 8 bits, then one ACK slot.
- DEV:
  - Match on DEV_ADDR with R/W=0 -> ACK, then ADDR_H (or ADDR_L, see Configuration).
  - Match with R/W=1 -> ACK, then RDATA from the current pointer.
  - Mismatch -> NACK (sda_oe stays 0), go to IDLE; all traffic is ignored until the next START.
- ADDR_L: after its ACK, pointer <= received address[AW-1:0], then WDATA.
- WDATA: each byte is ACKed and written at the pointer, pulsing wr_stb; pointer then increments.
- RDATA:
  - Load memory[pointer] and drive bits; sda_oe = ~bit.
  - In RDATA_ACK the block releases SDA and samples the master's bit. 0 -> pointer+1, next byte. 1 (NACK) -> IDLE, busy stays 1 until STOP/START.
- Pointer arithmetic is modulo 2**AW; it wraps from 2**AW-1 to 0 for both reads and writes.
- START in any state (repeated start) -> DEV, bit counter 0, sda_oe 0. The pointer is preserved, so write-address-then-restart-read yields a random read.
- STOP in any state -> IDLE, sda_oe 0, busy 0. A partial byte is discarded and never written.
- Memory contents are not reset; they are undefined until written.
- Reset mid-transfer: every state and output returns to reset values immediately. The pointer resets to 0.

## Timing
- Reset values: sda_oe=0, wr_stb=0, wr_addr=0, wr_data=0, busy=0, state IDLE, pointer 0.
- Detection latency: a pad edge is seen 3 clk after it occurs.
- SDA drive changes:
  - ACK assert, read-data bit change, and release all occur on the clk after the detected SCL fall.
  - Nothing changes while SCL is high, except the release on START/STOP.
- ACK hold: sda_oe is asserted from the fall after bit 8 until the fall after the ACK (9th) clock.
- wr_stb: 1-clk pulse on the clk after the detected SCL rise of the 8th data bit. wr_addr/wr_data are stable from that cycle until the next write.
- busy rises on the clk the device-address ACK is asserted.
- Simultaneous SCL edge and SDA change in the same sampled cycle: treated as a data bit, never as START/STOP.

## Configuration
- I2C_SLAVE_ADDR16_EN:
  - Defined: two word-address bytes (ADDR_H then ADDR_L); pointer <= {hi,lo}[AW-1:0].
  - Undefined: ADDR_H and ADDR_H_ACK are not compiled; DEV goes straight to ADDR_L, and one address byte sets the pointer.

## Test plan
- Write 0xA5 to address 0x0012 (DEV 0x50 W, addr, data, STOP) -> three ACKs; wr_stb once with wr_addr=0x12, wr_data=0xA5; busy drops after STOP.
- Random read at 0x0012 (write address, repeated START, DEV R, master NACK) -> 0xA5 shifted out; sda_oe released during the master ACK slot.
- Sequential write of 4 bytes at 0xFE with AW=8 -> writes land at 0xFE, 0xFF, 0x00, 0x01; a 4-byte read from 0xFE with ACK,ACK,ACK,NACK returns them in order.
- Device address 0x51 -> no ACK; sda_oe stays 0 for the whole transfer; no wr_stb.
- STOP after 5 data bits -> no wr_stb; state IDLE; a following valid write succeeds.
- Assert rst while the block is driving an ACK -> sda_oe=0 and busy=0 asynchronously; pointer 0.
